// File: rtl/mac_win_accum_pkg.sv
// Shared parameters and types for the windowed accumulator behind the multiply-add stage.
// Every other file in this block imports this package.
package mac_win_accum_pkg;

  localparam int unsigned P        = 8;
  localparam int unsigned DIN_W    = 2 * P;
  localparam int unsigned WIN_N    = 4;
  localparam int unsigned WIN_LOG2 = $clog2(WIN_N);
  localparam int unsigned ACC_W    = DIN_W + WIN_LOG2;

  typedef enum logic {S_IDLE, S_FILL} win_state_t;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [DIN_W-1:0] peak;
  } win_res_t;

  function automatic logic [DIN_W-1:0] max_din(input logic [DIN_W-1:0] a,
                                               input logic [DIN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mac_win_accum_if.sv
// Sample input and result output bundle of mac_win_accum.
// The master drives samples and ready; the slave returns the window result.
interface mac_win_accum_if import mac_win_accum_pkg::*; ();

  logic [DIN_W-1:0]    din;
  logic                din_vld;
  logic                out_rdy;
  logic                out_vld;
  logic [ACC_W-1:0]    sum;
  logic [DIN_W-1:0]    avg;
  logic [DIN_W-1:0]    peak;
  logic [WIN_LOG2-1:0] fill;
  logic                ovr;

  modport master (
    output din, din_vld, out_rdy,
    input  out_vld, sum, avg, peak, fill, ovr
  );

  modport slave (
    input  din, din_vld, out_rdy,
    output out_vld, sum, avg, peak, fill, ovr
  );

endinterface

// File: rtl/mac_win_hold.sv
// Output register for a completed window with valid/ready handshake.
// A result arriving while the previous one is still unconsumed is dropped and flagged in ovr.
module mac_win_hold import mac_win_accum_pkg::*; #(
  parameter type res_t = win_res_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  res_t res_new,
  input  logic out_rdy,
  output logic out_vld,
  output res_t res,
  output logic ovr
);

  logic vld_q, vld_d;
  res_t res_q, res_d;
  logic ovr_q, ovr_d;

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    ovr_d = ovr_q;
    if (clr) begin
      vld_d = 1'b0;
      res_d = '0;
      ovr_d = 1'b0;
    end else if (load) begin
      // A same-cycle handshake frees the register for the new result.
      if (!vld_q || out_rdy) begin
        res_d = res_new;
        vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      res_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      ovr_q <= ovr_d;
    end
  end

  assign out_vld = vld_q;
  assign res     = res_q;
  assign ovr     = ovr_q;

endmodule

// File: rtl/mac_win_accum.sv
// Collects WIN_N valid samples into a window and reports sum, average and peak.
// Window FSM and accumulator live here; the result register is mac_win_hold.
module mac_win_accum import mac_win_accum_pkg::*; (
  input  logic            C,
  input  logic            nRST,
  input  logic            CLR,
  mac_win_accum_if.slave  bus
);

  localparam logic [WIN_LOG2-1:0] LastFill = WIN_LOG2'(WIN_N - 1);

  win_state_t          state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DIN_W-1:0]    peak_q, peak_d;
  logic [WIN_LOG2-1:0] fill_q, fill_d;
  win_res_t            res_new;
  win_res_t            res_out;
  logic                complete;
  logic                out_vld;
  logic                ovr;

  always_comb begin
    res_new.sum  = acc_q + ACC_W'(bus.din);
    res_new.peak = max_din(peak_q, bus.din);
    complete     = bus.din_vld && (state_q == S_FILL) && (fill_q == LastFill) && !CLR;

    state_d = state_q;
    acc_d   = acc_q;
    peak_d  = peak_q;
    fill_d  = fill_q;
    if (CLR) begin
      state_d = S_IDLE;
      acc_d   = '0;
      peak_d  = '0;
      fill_d  = '0;
    end else if (bus.din_vld) begin
      unique case (state_q)
        S_IDLE: begin
          acc_d   = ACC_W'(bus.din);
          peak_d  = bus.din;
          fill_d  = WIN_LOG2'(1);
          state_d = S_FILL;
        end
        S_FILL: begin
          if (fill_q == LastFill) begin
            acc_d   = '0;
            peak_d  = '0;
            fill_d  = '0;
            state_d = S_IDLE;
          end else begin
            acc_d  = res_new.sum;
            peak_d = res_new.peak;
            fill_d = fill_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge C or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      peak_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      peak_q  <= peak_d;
      fill_q  <= fill_d;
    end
  end

  mac_win_hold #(
    .res_t (win_res_t)
  ) u_hold (
    .clk     (C),
    .rst_n   (nRST),
    .clr     (CLR),
    .load    (complete),
    .res_new (res_new),
    .out_rdy (bus.out_rdy),
    .out_vld (out_vld),
    .res     (res_out),
    .ovr     (ovr)
  );

  assign bus.out_vld = out_vld;
  assign bus.sum     = res_out.sum;
  assign bus.avg     = res_out.sum[ACC_W-1 -: DIN_W];
  assign bus.peak    = res_out.peak;
  assign bus.fill    = fill_q;
  assign bus.ovr     = ovr;

endmodule

// File: tb/tb_mac_win_accum.sv
// Scoreboard bench for mac_win_accum: directed windows followed by random traffic,
// checked against a window-of-samples reference model.
module tb_mac_win_accum;
  import mac_win_accum_pkg::*;

  logic C = 1'b0;
  logic nRST;
  logic CLR;

  mac_win_accum_if bus ();

  mac_win_accum dut (
    .C    (C),
    .nRST (nRST),
    .CLR  (CLR),
    .bus  (bus)
  );

  always #5 C = ~C;

  int tests = 0;
  int fails = 0;

  logic [DIN_W-1:0] win[$];
  win_res_t         sbq[$];
  bit               m_pend;
  bit               m_ovr;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic win_res_t ref_window();
    win_res_t r;
    longint   s;
    longint   pk;
    s  = 0;
    pk = 0;
    foreach (win[i]) begin
      s += win[i];
      if (win[i] > pk) pk = win[i];
    end
    r.sum  = ACC_W'(s);
    r.peak = DIN_W'(pk);
    return r;
  endfunction

  // Reference model: a window is simply the list of samples taken since it started.
  always @(posedge C or negedge nRST) begin : model
    bit       done;
    win_res_t r;
    if (!nRST || CLR) begin
      win.delete();
      sbq.delete();
      m_pend = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      done = 1'b0;
      r    = '0;
      if (bus.din_vld) begin
        win.push_back(bus.din);
        if (win.size() == WIN_N) begin
          r = ref_window();
          win.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!m_pend || bus.out_rdy) begin
          sbq.push_back(r);
          m_pend = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_pend && bus.out_rdy) begin
        m_pend = 1'b0;
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires results on a handshake.
  always @(negedge C) begin
    if (nRST) begin
      chk("mon_fill", bus.fill, win.size());
      chk("mon_ovr", bus.ovr, m_ovr);
      chk("mon_out_vld", bus.out_vld, m_pend);
      if (bus.out_vld) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mon_result: out_vld=1 with no expected result (t=%0t)", $time);
        end else begin
          chk("mon_sum", bus.sum, sbq[0].sum);
          chk("mon_avg", bus.avg, sbq[0].sum >> WIN_LOG2);
          chk("mon_peak", bus.peak, sbq[0].peak);
          if (bus.out_rdy && !CLR) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit vld, input logic [DIN_W-1:0] d, input bit rdy, input bit clr);
    bus.din_vld = vld;
    bus.din     = d;
    bus.out_rdy = rdy;
    CLR         = clr;
    @(posedge C);
    #1;
  endtask

  initial begin
    int pat[7];
    int fexp[7];
    pat  = '{1, 0, 0, 1, 1, 0, 1};
    fexp = '{1, 1, 1, 2, 3, 3, 0};

    nRST        = 1'b0;
    CLR         = 1'b0;
    bus.din     = '0;
    bus.din_vld = 1'b0;
    bus.out_rdy = 1'b0;
    #3;
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_avg", bus.avg, 0);
    chk("rst_peak", bus.peak, 0);
    chk("rst_fill", bus.fill, 0);
    chk("rst_ovr", bus.ovr, 0);
    #9 nRST = 1'b1;
    @(posedge C);
    #1;

    // Basic window
    cyc(1, 10, 1, 0); cyc(1, 20, 1, 0); cyc(1, 30, 1, 0); cyc(1, 40, 1, 0);
    chk("t1_vld", bus.out_vld, 1);
    chk("t1_sum", bus.sum, 100);
    chk("t1_avg", bus.avg, 25);
    chk("t1_peak", bus.peak, 40);
    cyc(0, 0, 1, 0);
    chk("t1_vld_drop", bus.out_vld, 0);

    // Full-scale samples must not wrap
    repeat (4) cyc(1, 16'hFFFF, 1, 0);
    chk("t2_sum", bus.sum, 18'h3FFFC);
    chk("t2_avg", bus.avg, 16'hFFFF);
    chk("t2_peak", bus.peak, 16'hFFFF);
    cyc(0, 0, 1, 0);

    // Gapped valids
    for (int i = 0; i < 7; i++) begin
      cyc(pat[i][0], 5, 1, 0);
      chk("t3_fill", bus.fill, fexp[i]);
    end
    chk("t3_sum", bus.sum, 20);
    chk("t3_vld", bus.out_vld, 1);
    cyc(0, 0, 1, 0);

    // Overrun while the consumer stalls
    cyc(1, 10, 0, 0); cyc(1, 20, 0, 0); cyc(1, 30, 0, 0); cyc(1, 40, 0, 0);
    chk("t4_sum_first", bus.sum, 100);
    repeat (4) cyc(1, 2, 0, 0);
    chk("t4_sum_kept", bus.sum, 100);
    chk("t4_ovr", bus.ovr, 1);
    chk("t4_vld", bus.out_vld, 1);
    cyc(0, 0, 1, 0);
    chk("t4_vld_drop", bus.out_vld, 0);
    chk("t4_ovr_sticky", bus.ovr, 1);
    chk("t4_sum_hold", bus.sum, 100);

    // Completion on the same edge as a handshake
    cyc(0, 0, 0, 1);
    chk("t5_clr_ovr", bus.ovr, 0);
    chk("t5_clr_sum", bus.sum, 0);
    cyc(1, 10, 0, 0); cyc(1, 20, 0, 0); cyc(1, 30, 0, 0); cyc(1, 40, 0, 0);
    cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0);
    cyc(1, 2, 1, 0);
    chk("t5_sum", bus.sum, 8);
    chk("t5_vld", bus.out_vld, 1);
    chk("t5_ovr", bus.ovr, 0);
    cyc(0, 0, 1, 0);

    // Clear mid-window, then async reset mid-window
    cyc(1, 7, 0, 0); cyc(1, 7, 0, 0);
    chk("t6_fill2", bus.fill, 2);
    cyc(0, 0, 0, 1);
    chk("t6_clr_fill", bus.fill, 0);
    repeat (4) cyc(1, 1, 0, 0);
    chk("t6_sum", bus.sum, 4);
    chk("t6_ovr", bus.ovr, 0);
    cyc(1, 9, 0, 0); cyc(1, 9, 0, 0);
    #2 nRST = 1'b0;
    #1;
    chk("t6_rst_vld", bus.out_vld, 0);
    chk("t6_rst_sum", bus.sum, 0);
    chk("t6_rst_avg", bus.avg, 0);
    chk("t6_rst_peak", bus.peak, 0);
    chk("t6_rst_fill", bus.fill, 0);
    #2 nRST = 1'b1;
    repeat (4) cyc(1, 1, 1, 0);
    chk("t6_sum_after_rst", bus.sum, 4);
    cyc(0, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom % 10) < 7,
          (($urandom % 4) == 0) ? 16'hFFFF : DIN_W'($urandom),
          ($urandom % 10) < 6,
          ($urandom % 50) == 0);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
